// File: rtl/hevc_size_pkg.sv
// Size constants and helpers shared by derive_real_size and derive_ext_size.
// MONO collapses the tag field to zero width (single flux).
package hevc_size_pkg;

    localparam int unsigned DATA_WIDTH = 7;
    localparam int unsigned DIFF       = 8;

    typedef logic [DATA_WIDTH-1:0] size_t;

    function automatic int unsigned tag_width(input int unsigned flux);
`ifdef MONO
        return (flux > 0) ? 0 : 0;
`else
        return (flux > 1) ? $clog2(flux) : 0;
`endif
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past i_last, and
// the caller owns the last-grant register.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_gnt_valid,
    output logic [IW-1:0] o_gnt_idx
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = IW'((32'(i_last) + k) % N);
            if (!o_gnt_valid && i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/derive_ext_size.sv
// Pops tagged real sizes round-robin across fluxes and pushes {tag, size+DIFF}
// through a single stall-holding output register. DERIVE_EXT_SIZE_SAT_EN clips.
module derive_ext_size #(
`ifdef MONO
    parameter int unsigned FLUX       = 1,
`else
    parameter int unsigned FLUX       = 2,
`endif
    parameter int unsigned DATA_WIDTH = hevc_size_pkg::DATA_WIDTH,
    parameter int unsigned DIFF       = hevc_size_pkg::DIFF,
    parameter int unsigned TAG_WIDTH  = hevc_size_pkg::tag_width(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FLUX-1:0]                 i_rd_empty,
    output logic [FLUX-1:0]                 o_rd_read,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0] i_rd_dout,
    input  logic [FLUX-1:0]                 i_wr_full,
    output logic                            o_wr_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] o_wr_din
);
    import hevc_size_pkg::*;

    localparam int unsigned IW = (FLUX > 1) ? $clog2(FLUX) : 1;

    logic                  r_out_valid;
    logic [IW-1:0]         r_out_tag;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [IW-1:0]         r_last_grant;

    logic                  w_write;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_gnt_valid;
    logic [IW-1:0]         w_gnt_idx;
    logic [FLUX-1:0]       w_elig;
    logic [DATA_WIDTH-1:0] w_sum;

    assign w_write  = r_out_valid & ~i_wr_full[r_out_tag];
    assign w_accept = ~r_out_valid | w_write;
    assign w_elig   = ~i_rd_empty & ~i_wr_full;
    // rst_n gates the read so a pending pop is suppressed the instant reset asserts
    assign w_take   = rst_n & w_accept & w_gnt_valid;

    rr_arbiter #(
        .N (FLUX)
    ) u_arb (
        .i_req       (w_elig),
        .i_last      (r_last_grant),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    always_comb begin
        o_rd_read = '0;
        if (w_take) begin
            o_rd_read[w_gnt_idx] = 1'b1;
        end
    end

    assign o_wr_write = w_write;

    generate
        if (TAG_WIDTH == 0) begin : g_mono
            assign o_wr_din = r_out_data;
        end else begin : g_tagged
            logic w_unused_tag;
            assign w_unused_tag = ^i_rd_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            assign o_wr_din     = {r_out_tag[TAG_WIDTH-1:0], r_out_data};
        end
    endgenerate

`ifdef DERIVE_EXT_SIZE_SAT_EN
    logic [DATA_WIDTH:0] w_sum_wide;
    logic                r_sat_seen;

    assign w_sum_wide = {1'b0, i_rd_dout[DATA_WIDTH-1:0]} + (DATA_WIDTH+1)'(DIFF);
    assign w_sum      = w_sum_wide[DATA_WIDTH] ? '1 : w_sum_wide[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_seen <= 1'b0;
        end else if (w_take && w_sum_wide[DATA_WIDTH]) begin
            r_sat_seen <= 1'b1;
        end
    end
`else
    assign w_sum = i_rd_dout[DATA_WIDTH-1:0] + DATA_WIDTH'(DIFF);
`endif

    // A drain and a new grant in the same cycle overwrite the register: no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_tag    <= '0;
            r_out_data   <= '0;
            r_last_grant <= IW'(FLUX - 1);
        end else if (w_accept) begin
            if (w_gnt_valid) begin
                r_out_valid  <= 1'b1;
                r_out_tag    <= w_gnt_idx;
                r_out_data   <= w_sum;
                r_last_grant <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_derive_ext_size.sv
// Bench for derive_ext_size (FLUX=2, DIFF=8): FWFT FIFO models, a per-cycle
// reference model and directed literal checks. Honours DERIVE_EXT_SIZE_SAT_EN.
module tb_derive_ext_size;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] empty;
    logic [1:0] read;
    logic [7:0] dout;
    logic [1:0] full = 2'b00;
    logic       write;
    logic [7:0] din;

    int n_checks = 0;
    int n_err    = 0;

    logic [6:0] mem [2][32];
    int         head [2];
    int         tail [2];

    int m_valid = 0;
    int m_tag   = 0;
    int m_data  = 0;
    int m_last  = 1;

    always #5 clk = ~clk;

    derive_ext_size dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_empty (empty),
        .o_rd_read  (read),
        .i_rd_dout  (dout),
        .i_wr_full  (full),
        .o_wr_write (write),
        .o_wr_din   (din)
    );

    assign empty[0] = (head[0] == tail[0]);
    assign empty[1] = (head[1] == tail[1]);
    assign dout = read[1] ? {1'b1, mem[1][5'(head[1])]} : {1'b0, mem[0][5'(head[0])]};

    initial begin
        head[0] = 0; head[1] = 0; tail[0] = 0; tail[1] = 0;
    end

    always @(posedge clk) begin
        if (read[0]) head[0] <= head[0] + 1;
        if (read[1]) head[1] <= head[1] + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int f, input int v);
        mem[f][5'(tail[f])] = 7'(v);
        tail[f] = tail[f] + 1;
    endtask

    task automatic reset_begin();
        @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    task automatic reset_end();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: expected outputs from the held token, FIFO fronts and full flags
    always @(negedge clk) begin : model
        int g;
        int s;
        int idx;
        logic ew;
        logic [1:0] er;
        if (!rst_n) begin
            chk("rst_read", 32'(read), 0);
            chk("rst_write", 32'(write), 0);
            chk("rst_din", 32'(din), 0);
            m_valid = 0; m_tag = 0; m_data = 0; m_last = 1;
        end else begin
            ew = (m_valid != 0) && !full[m_tag];
            g  = -1;
            if (m_valid == 0 || ew) begin
                for (int k = 1; k <= 2; k++) begin
                    idx = (m_last + k) % 2;
                    if (g < 0 && head[idx] != tail[idx] && !full[idx]) g = idx;
                end
            end
            er = (g >= 0) ? (2'b01 << g) : 2'b00;
            chk("model_read", 32'(read), 32'(er));
            chk("model_write", 32'(write), 32'(ew));
            if (m_valid != 0) chk("model_din", 32'(din), 32'(m_tag * 128 + m_data));
            if (m_valid == 0 || ew) begin
                if (g >= 0) begin
                    s = int'(mem[g][5'(head[g])]) + 8;
`ifdef DERIVE_EXT_SIZE_SAT_EN
                    m_data = (s > 127) ? 127 : s;
`else
                    m_data = s % 128;
`endif
                    m_valid = 1; m_tag = g; m_last = g;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    initial begin
        // 1: single token {0,64} -> read then din {0,72}, then idle
        reset_begin();
        push(0, 64);
        reset_end();
        @(negedge clk); chk("t1_read", 32'(read), 32'h1);
        @(negedge clk); chk("t1_write", 32'(write), 1); chk("t1_din", 32'(din), 32'h48);
        @(negedge clk); chk("t1_idle", 32'(write), 0);

        // 2: both fluxes loaded -> alternating grants, four back-to-back writes
        reset_begin();
        push(0, 8); push(0, 16); push(1, 32); push(1, 4);
        reset_end();
        @(negedge clk); chk("t2_rd0", 32'(read), 32'h1);
        @(negedge clk); chk("t2_din0", 32'(din), 32'h10); chk("t2_wr0", 32'(write), 1);
        chk("t2_rd1", 32'(read), 32'h2);
        @(negedge clk); chk("t2_din1", 32'(din), 32'hA8); chk("t2_wr1", 32'(write), 1);
        @(negedge clk); chk("t2_din2", 32'(din), 32'h18); chk("t2_wr2", 32'(write), 1);
        @(negedge clk); chk("t2_din3", 32'(din), 32'h8C); chk("t2_wr3", 32'(write), 1);
        @(negedge clk); chk("t2_done", 32'(write), 0);

        // 3: stall on full[1] while holding {1,40}
        reset_begin();
        push(1, 32);
        reset_end();
        @(negedge clk); chk("t3_rd1", 32'(read), 32'h2);
        @(posedge clk);
        #1 full = 2'b10;
        push(0, 8);
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_wr", 32'(write), 0);
            chk("t3_stall_din", 32'(din), 32'hA8);
            chk("t3_stall_rd", 32'(read), 0);
        end
        @(posedge clk);
        #1 full = 2'b00;
        @(negedge clk); chk("t3_rel_wr", 32'(write), 1); chk("t3_rel_din", 32'(din), 32'hA8);
        chk("t3_rel_rd", 32'(read), 32'h1);
        @(negedge clk); chk("t3_next_din", 32'(din), 32'h10);

        // 4: full[0] blocks flux 0; served right after release
        reset_begin();
        full = 2'b01;
        push(0, 8); push(1, 32);
        reset_end();
        @(negedge clk); chk("t4_rd1", 32'(read), 32'h2);
        @(negedge clk); chk("t4_wr", 32'(write), 1); chk("t4_nord", 32'(read), 0);
        @(negedge clk); chk("t4_idle_rd", 32'(read), 0);
        @(posedge clk);
        #1 full = 2'b00;
        @(negedge clk); chk("t4_rd0", 32'(read), 32'h1);
        @(negedge clk); chk("t4_din0", 32'(din), 32'h10);

        // 5: reset mid-operation with a held token and pending read
        reset_begin();
        push(0, 8); push(0, 16);
        reset_end();
        @(negedge clk); chk("t5_rd", 32'(read), 32'h1);
        @(posedge clk);
        #1 chk("t5_pre_wr", 32'(write), 1); chk("t5_pre_rd", 32'(read), 32'h1);
        rst_n = 1'b0;
        #1 chk("t5_rst_wr", 32'(write), 0); chk("t5_rst_rd", 32'(read), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(1, 4);
        @(negedge clk); chk("t5_first_gnt", 32'(read), 32'h1);
        repeat (6) @(negedge clk);

        // 6: near-overflow input {0,125}
        reset_begin();
        push(0, 125);
        reset_end();
`ifdef DERIVE_EXT_SIZE_SAT_EN
        chk("t6_sat_clr", 32'(dut.r_sat_seen), 0);
`endif
        @(negedge clk); chk("t6_rd", 32'(read), 32'h1);
        @(negedge clk); chk("t6_wr", 32'(write), 1);
`ifdef DERIVE_EXT_SIZE_SAT_EN
        chk("t6_din_sat", 32'(din), 32'h7F);
        chk("t6_sat_seen", 32'(dut.r_sat_seen), 1);
`else
        chk("t6_din_wrap", 32'(din), 32'h05);
`endif
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
